// File: rtl/output_serializer.sv
// Block-to-word serializer: whole ciphertext blocks enter a small FIFO and
// leave as OUT_W-bit words under a valid/ready handshake.
module output_serializer #(
  parameter int BLOCK_W   = 128,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         in_valid,
  input  logic [BLOCK_W-1:0]           in_data,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             data_out,
  output logic                         data_ok,
  input  logic                         out_ready,
  output logic                         output_read,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int BEATS  = BLOCK_W / OUT_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [BLOCK_W-1:0] shreg;
  logic [BLOCK_W-1:0] shifted;
  logic [OUT_W-1:0]   word;
  logic [BEAT_W-1:0]  beat;
  logic               push;
  logic               pop;
  logic               accept;
  logic               last_beat;
  logic               fifo_empty;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop happens either when IDLE picks up a block or when the final beat
  // is accepted with another block waiting, which gives back-to-back output.
  always_comb begin
    in_ready   = fifo_level < LVL_W'(DEPTH);
    fifo_empty = (fifo_level == '0);
    push       = in_valid && in_ready;
    accept     = (state == SEND) && out_ready;
    last_beat  = (beat == BEAT_W'(BEATS - 1));
    pop        = !fifo_empty && ((state == IDLE) || (accept && last_beat));
    data_ok    = (state == SEND);
    if (LSB_FIRST != 0) begin
      word    = shreg[OUT_W-1:0];
      shifted = shreg >> OUT_W;
    end else begin
      word    = shreg[BLOCK_W-1 -: OUT_W];
      shifted = shreg << OUT_W;
    end
    data_out = data_ok ? word : '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      shreg       <= '0;
      beat        <= '0;
      output_read <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      output_read <= 1'b0;
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);

      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            beat  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (last_beat) begin
              output_read <= 1'b1;
              beat        <= '0;
              if (pop) shreg <= mem[rd_ptr];
              else     state <= IDLE;
            end else begin
              shreg <= shifted;
              beat  <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_serializer.sv
// Scoreboard bench for output_serializer: an MSB-first and an LSB-first
// instance share stimulus; a negedge monitor checks every presented word.
module tb_output_serializer;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;

  logic         in_ready    [2];
  logic [7:0]   data_out    [2];
  logic         data_ok     [2];
  logic         output_read [2];
  logic         overflow    [2];
  logic [1:0]   fifo_level  [2];

  int           tests  = 0;
  int           errors = 0;
  logic [7:0]   exp_q [2][$];
  int           beat_cnt [2];
  bit           pend [2];

  always #5 clk = ~clk;

  output_serializer #(.BLOCK_W(128), .OUT_W(8), .DEPTH(2), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .data_out(data_out[0]), .data_ok(data_ok[0]),
    .out_ready(out_ready), .output_read(output_read[0]),
    .overflow(overflow[0]), .fifo_level(fifo_level[0])
  );

  output_serializer #(.BLOCK_W(128), .OUT_W(8), .DEPTH(2), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .data_out(data_out[1]), .data_ok(data_ok[1]),
    .out_ready(out_ready), .output_read(output_read[1]),
    .overflow(overflow[1]), .fifo_level(fifo_level[1])
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one block for a cycle; the caller clears in_valid via idle_inputs.
  task automatic apply_stimulus(input logic [127:0] b, input bit expect_accept);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    if (expect_accept) begin
      for (int i = 0; i < 16; i++) begin
        exp_q[0].push_back(b[127-8*i -: 8]);
        exp_q[1].push_back(b[8*i +: 8]);
      end
    end
  endtask

  task automatic idle_inputs();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !data_ok[0] && !data_ok[1])
        break;
    end
    check_output("drain_left", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("%s_data_ok%0d", tag, i), 32'(data_ok[i]), 32'd0);
      check_output($sformatf("%s_data_out%0d", tag, i), 32'(data_out[i]), 32'd0);
      check_output($sformatf("%s_in_ready%0d", tag, i), 32'(in_ready[i]), 32'd1);
      check_output($sformatf("%s_output_read%0d", tag, i), 32'(output_read[i]), 32'd0);
      check_output($sformatf("%s_overflow%0d", tag, i), 32'(overflow[i]), 32'd0);
      check_output($sformatf("%s_fifo_level%0d", tag, i), 32'(fifo_level[i]), 32'd0);
    end
  endtask

  // Monitor: output_read must follow exactly the cycle after each 16th accept.
  always @(negedge clk) begin
    if (!rst_) begin
      for (int i = 0; i < 2; i++) begin
        beat_cnt[i] = 0;
        pend[i]     = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        check_output($sformatf("output_read%0d", i), 32'(output_read[i]), 32'(pend[i]));
        pend[i] = 1'b0;
        if (data_ok[i]) begin
          if (exp_q[i].size() == 0) begin
            check_output($sformatf("unexpected_word%0d", i), 32'(data_ok[i]), 32'd0);
          end else begin
            check_output($sformatf("data_out%0d", i), 32'(data_out[i]), 32'(exp_q[i][0]));
            if (out_ready) begin
              void'(exp_q[i].pop_front());
              beat_cnt[i]++;
              if (beat_cnt[i] == 16) begin
                beat_cnt[i] = 0;
                pend[i]     = 1'b1;
              end
            end
          end
        end else begin
          check_output($sformatf("idle_data_out%0d", i), 32'(data_out[i]), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int run;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst_ = 1'b1;

    // Single block: latency of two cycles from push to first word.
    apply_stimulus(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
    idle_inputs();
    @(negedge clk);
    check_output("latency_early", 32'(data_ok[0]), 32'd0);
    @(negedge clk);
    check_output("latency_ok", 32'(data_ok[0]), 32'd1);
    check_output("first_word_msb", 32'(data_out[0]), 32'h00);
    check_output("first_word_lsb", 32'(data_out[1]), 32'hFF);
    wait_drain();
    check_output("level_after_single", 32'(fifo_level[0]), 32'd0);

    // Two blocks back to back: 32 gapless words.
    apply_stimulus(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b1);
    apply_stimulus(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1);
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (data_ok[0]) break;
    end
    run = 0;
    while (data_ok[0] && run < 100) begin
      run++;
      @(negedge clk); #1;
    end
    check_output("gapless_words", 32'(run), 32'd32);
    wait_drain();

    // Back-pressure pattern 1,0,0 repeating.
    apply_stimulus(128'hDEADBEEFCAFEBABE0011223344556677, 1'b1);
    idle_inputs();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      out_ready = (k % 3 == 0);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !data_ok[0]) break;
    end
    out_ready = 1'b1;
    wait_drain();

    // Fill: one in the shifter, two in the FIFO, the fourth overflows.
    @(posedge clk); #1;
    out_ready = 1'b0;
    apply_stimulus(128'h11111111111111111111111111111111, 1'b1);
    apply_stimulus(128'h2222222222222222222222222222222F, 1'b1);
    apply_stimulus(128'h3333333333333333333333333333333E, 1'b1);
    @(negedge clk);
    check_output("level_before_full", 32'(fifo_level[0]), 32'd1);
    check_output("overflow_before", 32'(overflow[0]), 32'd0);
    apply_stimulus(128'h44444444444444444444444444444444, 1'b0);
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("full_level%0d", i), 32'(fifo_level[i]), 32'd2);
      check_output($sformatf("full_in_ready%0d", i), 32'(in_ready[i]), 32'd0);
      check_output($sformatf("overflow_set%0d", i), 32'(overflow[i]), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    check_output("overflow_sticky", 32'(overflow[0]), 32'd1);

    // Reset in the middle of a block with another block queued.
    apply_stimulus(128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0, 1'b1);
    apply_stimulus(128'h8899AABBCCDDEEFF0011223344556677, 1'b1);
    idle_inputs();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (exp_q[0].size() <= 27) break;
    end
    check_output("pre_reset_words_left", 32'(exp_q[0].size()), 32'd27);
    rst_ = 1'b0;
    #1;
    check_reset_state("midreset");
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_ = 1'b1;
    apply_stimulus(128'hCAFEF00D123456789ABCDEF013579BDF, 1'b1);
    idle_inputs();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
